// File: rtl/cond_logic_unit_pkg.sv
// Shared constants for the condition logic unit:
// condition codes, NZCV bit positions and FlagW group bits.
package cond_logic_unit_pkg;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam int FLAGW_NZ = 1;
   localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_logic_unit_if.sv
// Decoder/ALU side bundle of the condition logic unit.
// master drives the request side, slave is the unit itself.
interface cond_logic_unit_if;

   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS;
   logic       RegW;
   logic       MemW;
   logic       NoWrite;
   logic       Stall;

   logic       CondEx;
   logic       PCSrc;
   logic       RegWrite;
   logic       MemWrite;
   logic [3:0] Flags;
   logic       C_Flag;

   modport master (
      output Cond, ALUFlags, FlagW, PCS,
      output RegW, MemW, NoWrite, Stall,
      input  CondEx, PCSrc, RegWrite,
      input  MemWrite, Flags, C_Flag
   );

   modport slave (
      input  Cond, ALUFlags, FlagW, PCS,
      input  RegW, MemW, NoWrite, Stall,
      output CondEx, PCSrc, RegWrite,
      output MemWrite, Flags, C_Flag
   );

endinterface

// File: rtl/cond_logic_unit_cond_check.sv
// Pure combinational condition evaluator: Cond + NZCV -> pass.
// Kept standalone so other front-end logic can reuse it.
module cond_check
   import cond_logic_unit_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       cond_ex
);

   logic n, z, c, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   always_comb begin
      cond_ex = 1'b0;
      unique case (cond)
         COND_EQ: cond_ex = z;
         COND_NE: cond_ex = ~z;
         COND_CS: cond_ex = c;
         COND_CC: cond_ex = ~c;
         COND_MI: cond_ex = n;
         COND_PL: cond_ex = ~n;
         COND_VS: cond_ex = v;
         COND_VC: cond_ex = ~v;
         COND_HI: cond_ex = c & ~z;
         COND_LS: cond_ex = ~c | z;
         COND_GE: cond_ex = (n == v);
         COND_LT: cond_ex = (n != v);
         COND_GT: cond_ex = ~z & (n == v);
         COND_LE: cond_ex = z | (n != v);
         COND_AL: cond_ex = 1'b1;
         COND_NV: cond_ex = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_logic_unit.sv
// Architectural NZCV register with group write enables and
// condition gating of the PC/register/memory write strobes.
module cond_logic_unit
   import cond_logic_unit_pkg::*;
#(
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input logic           CLK,
   input logic           RESET,
   cond_logic_unit_if.slave bus
);

   logic [3:0] flags_q;
   logic       cond_ex;
   logic       go;

   cond_check u_cond_check (
      .cond    (bus.Cond),
      .flags   (flags_q),
      .cond_ex (cond_ex)
   );

   // Only completing, passing instructions may commit anything.
   assign go = cond_ex & ~bus.Stall & ~RESET;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         flags_q <= RESET_FLAGS;
      end else if (go) begin
         if (bus.FlagW[FLAGW_NZ]) begin
            flags_q[FLAG_N] <= bus.ALUFlags[FLAG_N];
            flags_q[FLAG_Z] <= bus.ALUFlags[FLAG_Z];
         end
         if (bus.FlagW[FLAGW_CV]) begin
            flags_q[FLAG_C] <= bus.ALUFlags[FLAG_C];
            flags_q[FLAG_V] <= bus.ALUFlags[FLAG_V];
         end
      end
   end

   assign bus.CondEx   = cond_ex;
   assign bus.PCSrc    = bus.PCS & go;
   assign bus.RegWrite = bus.RegW & ~bus.NoWrite & go;
   assign bus.MemWrite = bus.MemW & go;
   assign bus.Flags    = flags_q;
   assign bus.C_Flag   = flags_q[FLAG_C];

endmodule
